count_sequencer: RTL
====================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the count and limit width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port start, input, 1 bit: request to begin a count sequence.
REQ-005 SHALL have port stop, input, 1 bit: abort the current sequence.
REQ-006 SHALL have port pause, input, 1 bit: level hold request while a sequence is active.
REQ-007 SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = periodic auto-reload; sampled together with limit on accepted start.
REQ-008 SHALL have port limit, input, WIDTH bits: terminal count value; sampled on accepted start.
REQ-009 SHALL have port en, output, 1 bit: count-enable strobe for the counter datapath.
REQ-010 SHALL have port q, output, WIDTH bits: current count value.
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN or PAUSE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle terminal-count pulse.

Function
REQ-013 SHALL implement states IDLE, RUN, and PAUSE, with all outputs derived from registered state.
REQ-014 In IDLE, start=1 with stop=0 SHALL latch limit into limit_r and mode into mode_r, clear q to 0, and enter RUN on that edge.
REQ-015 In IDLE, start=1 together with stop=1 SHALL leave the block in IDLE (stop wins).
REQ-016 en SHALL equal (state==RUN) AND NOT pause AND NOT stop, combinationally.
REQ-017 At each edge with en=1 and q != limit_r, q SHALL increment by 1.
REQ-018 At an edge with en=1 and q == limit_r, q SHALL become 0 and done SHALL be 1 for exactly the following cycle.
REQ-019 At that terminal edge, mode_r=0 SHALL move the state to IDLE (busy=0 the next cycle), and mode_r=1 SHALL keep the state in RUN.
REQ-020 limit_r=0 SHALL give a one-cycle sequence: q stays 0 and done pulses after each en cycle (continuously in periodic mode).
REQ-021 In RUN, pause=1 (with stop=0) SHALL enter PAUSE with q held; in PAUSE, pause=0 SHALL return to RUN with q unchanged.
REQ-022 stop=1 in RUN or PAUSE SHALL enter IDLE, clear q to 0, and produce no done pulse, even if q == limit_r on that edge.
REQ-023 start SHALL be ignored in RUN and PAUSE, and limit and mode SHALL have no effect outside an accepted start.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH, and q SHALL never exceed limit_r.
REQ-025 done SHALL be registered and SHALL never be high for two consecutive cycles unless limit_r=0 in periodic mode.

Reset
REQ-026 reset=0 SHALL immediately (asynchronously) force state to IDLE, q=0, limit_r=0, mode_r=0, done=0, and busy=0, regardless of clk.
REQ-027 Assertion of reset mid-sequence SHALL discard the sequence with no done pulse, and the block SHALL require a new start after release.
REQ-028 After reset release, the first edge SHALL behave as in IDLE.

Verification
REQ-029 The bench SHALL cover one-shot counting: limit=3, mode=0, start for 1 cycle -> q reads 0,1,2,3, then 0 with done=1 for one cycle, then busy=0 and q stays 0.
REQ-030 The bench SHALL cover periodic counting: limit=2, mode=1 -> q sequence 0,1,2,0,1,2,... with done pulsing every 3 cycles and busy held at 1.
REQ-031 The bench SHALL cover pause: limit=5, pause=1 for 3 cycles at q=2 -> q holds at 2 and en=0, then after release q resumes 3,4,5 and done pulses.
REQ-032 The bench SHALL cover stop at terminal: limit=4, stop=1 in the cycle where q=4 -> IDLE, q=0, done stays 0.
REQ-033 The bench SHALL cover start and stop together in IDLE: start=1 and stop=1 -> busy stays 0 and q stays 0.
REQ-034 The bench SHALL cover asynchronous reset: reset=0 mid-cycle at q=3 of limit=7 -> q=0 and busy=0 before the next edge, with no done pulse.

Source files
------------

// File: rtl/count_sequencer.sv
// Start/stop/pause sequencer driving a counter from 0 up to a latched limit,
// with one-shot or periodic auto-reload and a registered terminal-count pulse.
module count_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = '0;
          limit_d = limit;
          mode_d  = mode;
        end
      end
      RUN: begin
        // stop outranks pause, which outranks counting; stop suppresses done
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (cnt_q == limit_q) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = mode_q ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    en   = (state_q == RUN) && !pause && !stop;
    busy = (state_q != IDLE);
    q    = cnt_q;
    done = done_q;
  end

endmodule
